// File: rtl/cache_ctrl_nway.sv
// Control FSM for a WAYS-way, WORDS-word-per-line cache over a fixed-latency pipelined memory.
// Optional hit/miss performance counters are enabled by defining CC_PERF_CNT_EN.
module cache_ctrl_nway #(
    parameter int WAYS    = 2,
    parameter int WORDS   = 4,
    parameter int MEM_LAT = 2,
    localparam int WW     = $clog2(WORDS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd,
    input  logic            wr,
    input  logic [WAYS-1:0] hit,
    input  logic [WAYS-1:0] valid,
    input  logic [WAYS-1:0] dirty,
    input  logic            mem_stall,
    output logic [WAYS-1:0] enable,
    output logic            comp,
    output logic            write,
    output logic            valid_in,
    output logic            use_cpu,
    output logic [WW-1:0]   word_sel,
    output logic            fill_src,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [WW-1:0]   mem_word,
    output logic            done,
    output logic            cache_hit,
`ifdef CC_PERF_CNT_EN
    output logic            err,
    output logic [15:0]     hit_cnt,
    output logic [15:0]     miss_cnt
`else
    output logic            err
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WB    = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_RETRY = 2'd3;
    localparam int         CW      = WW + 1;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;       // WB word index, or FILL issue index (reaches WORDS)
    logic            way_q;
    logic            victim;
    logic            way_sel;
    logic            miss_dirty;
    logic            hit_any;
    logic            issue;
    logic            ret_v;
    logic [WW-1:0]   ret_j;
    logic [WAYS-1:0] way_mask;

    assign hit_any  = |(hit & valid);
    assign way_mask = WAYS'(1) << way_q;
    assign issue    = (state == S_FILL) && (cnt < CW'(WORDS)) && !mem_stall;

    // Lowest invalid way wins; with every way valid the victim pointer decides.
    always_comb begin
        way_sel = victim;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) way_sel = 1'(i);
        end
    end
    assign miss_dirty = valid[way_sel] & dirty[way_sel];

    generate
        if (MEM_LAT == 1) begin : g_pipe0
            assign ret_v = issue;
            assign ret_j = cnt[WW-1:0];
        end else begin : g_pipe
            logic [MEM_LAT-2:0] pv;
            logic [WW-1:0]      pj [MEM_LAT-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                end else begin
                    pv[0] <= issue;
                    for (int i = 1; i < MEM_LAT - 1; i++) pv[i] <= pv[i-1];
                end
            end

            // NOTE: the index payload needs no reset; it is only looked at when its valid bit is set.
            always_ff @(posedge clk) begin
                pj[0] <= cnt[WW-1:0];
                for (int i = 1; i < MEM_LAT - 1; i++) pj[i] <= pj[i-1];
            end

            assign ret_v = pv[MEM_LAT-2];
            assign ret_j = pj[MEM_LAT-2];
        end
    endgenerate

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        enable    = '0;
        comp      = 1'b0;
        write     = 1'b0;
        valid_in  = 1'b0;
        use_cpu   = 1'b0;
        word_sel  = '0;
        fill_src  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_word  = '0;
        done      = 1'b0;
        cache_hit = 1'b0;
        err       = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (rd && wr) begin
                        err = 1'b1;
                    end else if (rd ^ wr) begin
                        comp    = 1'b1;
                        enable  = '1;
                        use_cpu = 1'b1;
                        write   = wr;
                        if (hit_any) begin
                            done      = 1'b1;
                            cache_hit = 1'b1;
                        end
                    end
                end
                S_WB: begin
                    enable   = way_mask;
                    word_sel = cnt[WW-1:0];
                    mem_word = cnt[WW-1:0];
                    mem_wr   = !mem_stall;
                end
                S_FILL: begin
                    mem_rd   = issue;
                    mem_word = issue ? cnt[WW-1:0] : '0;
                    if (ret_v) begin
                        enable   = way_mask;
                        write    = 1'b1;
                        fill_src = 1'b1;
                        word_sel = ret_j;
                        valid_in = (ret_j == WW'(WORDS - 1));
                    end
                end
                default: begin
                    comp    = 1'b1;
                    enable  = way_mask;
                    use_cpu = 1'b1;
                    write   = wr;
                    done    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            way_q  <= 1'b0;
            victim <= 1'b0;
        end else begin
            if (done && WAYS == 2) victim <= ~victim;
            case (state)
                S_IDLE: begin
                    if ((rd ^ wr) && !hit_any) begin
                        way_q <= way_sel;
                        cnt   <= '0;
                        state <= miss_dirty ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (!mem_stall) begin
                        if (cnt == CW'(WORDS - 1)) begin
                            cnt   <= '0;
                            state <= S_FILL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (issue) cnt <= cnt + 1'b1;
                    if (ret_v && ret_j == WW'(WORDS - 1)) state <= S_RETRY;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (done) begin
            if (cache_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 1'b1;
            if (!cache_hit && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif

endmodule
